// File: rtl/shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer
//
// Sequences an external left-shifting register as a parallel-to-serial
// transmitter. A word accepted on the in_valid/in_ready handshake is loaded
// into the register. It is then shifted out MSB first, one bit per cycle
// while hold is low. After each frame the block waits GAP_CYCLES idle cycles
// before it accepts the next word. An abort clears the register through sclr.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word (IDLE only, forced low in reset)
//   in_data    upstream word
//   hold       pause shifting while high (SHIFT state only)
//   abort      cancel the current frame (LOAD, SHIFT, GAP)
//   sr_load    register load control
//   sr_enable  register enable control
//   sr_sclr    register synchronous clear control
//   sr_data    captured word presented to the register data input
//   ser_valid  register shiftout carries a data bit this cycle
//   bit_cnt    index of the bit currently on shiftout (0 = MSB)
//   busy       state is LOAD, SHIFT or GAP
//   done       one-cycle pulse after the last bit of a frame
//   frame_cnt  completed frames, wrapping
// -----------------------------------------------------------------------------
module shift_reg_sequencer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     hold,
    input  logic                     abort,
    output logic                     sr_load,
    output logic                     sr_enable,
    output logic                     sr_sclr,
    output logic [WIDTH-1:0]         sr_data,
    output logic                     ser_valid,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int BW = $clog2(WIDTH);
    // gap_cnt needs at least one bit even when GAP_CYCLES is 0 or 1
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_data_q, sr_data_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLR;
            sr_data_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_data_q   <= sr_data_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_data_d   = sr_data_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_CLR: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end

            S_IDLE: begin
                if (in_valid) begin
                    sr_data_d = in_data;
                    state_d   = S_LOAD;
                end
            end

            // hold has no effect here: the register must capture the word
            S_LOAD: begin
                bit_cnt_d = '0;
                state_d   = abort ? S_CLR : S_SHIFT;
            end

            S_SHIFT: begin
                if (abort) begin
                    state_d   = S_CLR;
                    bit_cnt_d = '0;
                end else if (!hold) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        bit_cnt_d   = '0;
                        gap_cnt_d   = '0;
                        state_d     = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d   = S_CLR;
                    gap_cnt_d = '0;
                end else if (int'(gap_cnt_q) >= GAP_CYCLES - 1) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: state_d = S_CLR;
        endcase
    end

    // Outputs decode registered state; hold gates the shift enable in the
    // same cycle so a paused bit stays on shiftout and is not lost.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign sr_sclr   = (state_q == S_CLR);
    assign sr_load   = (state_q == S_LOAD);
    assign ser_valid = (state_q == S_SHIFT) && !hold;
    assign sr_enable = (state_q == S_LOAD) || ser_valid;
    assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_GAP);
    assign sr_data   = sr_data_q;
    assign bit_cnt   = bit_cnt_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
module tb_shift_reg_sequencer;

    localparam int GAP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default build: WIDTH=8, GAP_CYCLES=2, CNT_W=16
    logic        a_valid, a_ready, a_hold, a_abort;
    logic [7:0]  a_data, a_sr_data;
    logic        a_load, a_enable, a_sclr, a_ser_valid, a_busy, a_done;
    logic [2:0]  a_bit_cnt;
    logic [15:0] a_frame_cnt;

    shift_reg_sequencer dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .hold(a_hold), .abort(a_abort),
        .sr_load(a_load), .sr_enable(a_enable), .sr_sclr(a_sclr), .sr_data(a_sr_data),
        .ser_valid(a_ser_valid), .bit_cnt(a_bit_cnt), .busy(a_busy),
        .done(a_done), .frame_cnt(a_frame_cnt)
    );

    // behavioural left-shifting register driven by dut_a
    logic [7:0] srq = 8'h00;
    logic       shiftout;
    always @(posedge clk) begin
        if (a_sclr)        srq <= 8'h00;
        else if (a_load)   srq <= a_sr_data;
        else if (a_enable) srq <= {srq[6:0], 1'b0};
    end
    assign shiftout = srq[7];

    // wrap / zero-gap build: CNT_W=2, GAP_CYCLES=0
    logic       b_valid, b_ready, b_hold, b_abort;
    logic [7:0] b_data, b_sr_data;
    logic       b_load, b_enable, b_sclr, b_ser_valid, b_busy, b_done;
    logic [2:0] b_bit_cnt;
    logic [1:0] b_frame_cnt;

    shift_reg_sequencer #(.WIDTH(8), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .hold(b_hold), .abort(b_abort),
        .sr_load(b_load), .sr_enable(b_enable), .sr_sclr(b_sclr), .sr_data(b_sr_data),
        .ser_valid(b_ser_valid), .bit_cnt(b_bit_cnt), .busy(b_busy),
        .done(b_done), .frame_cnt(b_frame_cnt)
    );

    int total = 0;
    int bad   = 0;
    int exp_frames = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // one frame vector: stimulus timing in cycles relative to the accept cycle
    typedef struct {
        logic [7:0] data;
        int         hold_cyc;   // first hold cycle, -1 none
        int         hold_len;
        int         hold_bit;   // expected frozen bit_cnt while held, -1 no check
        int         abort_cyc;  // -1 none
        int         nbits;      // expected serial bits seen
        logic [7:0] bits;       // expected serial bits, first bit most significant
        int         done_cyc;   // 0 = no done
        int         ndone;
        int         sclr_cyc;   // 0 = no sclr before ready
        int         ready_cyc;
        int         frames;     // frame_cnt at the ready cycle
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int idx);
        int         nb = 0;
        logic [7:0] w  = 8'h00;
        int         dc = 0;
        int         nd = 0;
        int         sc = 0;
        int         rc = 0;
        for (int c = 0; c < 40 && rc == 0; c++) begin
            @(posedge clk); #1;
            a_valid = (c == 0);
            a_data  = v.data;
            a_hold  = (v.hold_cyc >= 0) && (c >= v.hold_cyc) && (c < v.hold_cyc + v.hold_len);
            a_abort = (c == v.abort_cyc);
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("v%0d_accept", idx), a_ready, 1);
            end else begin
                if (a_ser_valid) begin
                    w = {w[6:0], shiftout};
                    nb++;
                end
                if (a_done) begin
                    nd++;
                    if (dc == 0) dc = c;
                end
                if (a_sclr && sc == 0) sc = c;
                if (a_hold && v.hold_bit >= 0) begin
                    chk($sformatf("v%0d_hold_bitcnt", idx), a_bit_cnt, v.hold_bit);
                    chk($sformatf("v%0d_hold_serv", idx), a_ser_valid, 0);
                end
                if (a_ready) rc = c;
            end
        end
        chk($sformatf("v%0d_nbits", idx), nb, v.nbits);
        chk($sformatf("v%0d_bits", idx), w, v.bits);
        chk($sformatf("v%0d_done_cyc", idx), dc, v.done_cyc);
        chk($sformatf("v%0d_ndone", idx), nd, v.ndone);
        chk($sformatf("v%0d_sclr_cyc", idx), sc, v.sclr_cyc);
        chk($sformatf("v%0d_ready_cyc", idx), rc, v.ready_cyc);
        chk($sformatf("v%0d_fcnt", idx), a_frame_cnt, v.frames);
        chk($sformatf("v%0d_reg_q", idx), srq, 8'h00);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a_valid = 1'b0; a_hold = 1'b0; a_abort = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_data = 8'h00; a_hold = 1'b0; a_abort = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_hold = 1'b0; b_abort = 1'b0;

        //   data  hc  hl  hb  ac  nb bits  dc nd sc rc fr
        vecs[0] = '{8'hA5, -1, 0, -1, -1, 8, 8'hA5, 10, 1, 0, 12, 1};
        vecs[1] = '{8'h3C,  6, 3,  4, -1, 8, 8'h3C, 13, 1, 0, 15, 2};
        vecs[2] = '{8'hFF, -1, 0, -1,  7, 6, 8'h3F,  0, 0, 8,  9, 2};
        vecs[3] = '{8'h5A,  2, 2,  0, -1, 8, 8'h5A, 12, 1, 0, 14, 3};
        vecs[4] = '{8'h81, -1, 0, -1,  1, 0, 8'h00,  0, 0, 2,  3, 3};
        vecs[5] = '{8'hC3, -1, 0, -1, 10, 8, 8'hC3, 10, 1, 11, 12, 4};
        vecs[6] = '{8'h0F, 10, 2, -1, -1, 8, 8'h0F, 10, 1, 0, 12, 5};
        vecs[7] = '{8'h96,  1, 1, -1, -1, 8, 8'h96, 10, 1, 0, 12, 6};
        vecs[8] = '{8'h69, -1, 0, -1,  0, 8, 8'h69, 10, 1, 0, 12, 7};

        // reset: three cycles of rst, then the CLR cycle, then IDLE
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_in_ready", a_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("clr_sclr", a_sclr, 1);
        chk("clr_in_ready", a_ready, 0);
        chk("clr_load", a_load, 0);
        chk("clr_enable", a_enable, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_in_ready", a_ready, 1);
        chk("idle_busy", a_busy, 0);
        chk("idle_fcnt", a_frame_cnt, 0);
        chk("idle_done", a_done, 0);
        chk("idle_sclr", a_sclr, 0);

        // table of single frames with hold / abort corners
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
        exp_frames = 7;
        idle_cycles(1);

        // back-to-back frames with in_valid held high
        begin : b2b
            logic [7:0] bb[3];
            int nacc, nd, last, nb, fi;
            logic [7:0] w;
            bb[0] = 8'h01; bb[1] = 8'h80; bb[2] = 8'hC3;
            nacc = 0; nd = 0; last = 0; nb = 0; fi = 0; w = 8'h00;
            for (int c = 0; c < 80 && nd < 3; c++) begin
                @(posedge clk); #1;
                a_valid = (nacc < 3);
                a_data  = bb[(nacc < 3) ? nacc : 0];
                a_hold  = 1'b0;
                a_abort = 1'b0;
                @(negedge clk);
                if (a_valid && a_ready) begin
                    if (nacc > 0) chk("b2b_spacing", c - last, 12);
                    last = c;
                    nacc++;
                end
                if (a_ser_valid) begin
                    w = {w[6:0], shiftout};
                    nb++;
                    if (nb == 8) begin
                        chk($sformatf("b2b_word%0d", fi), w, bb[fi]);
                        fi++;
                        nb = 0;
                    end
                end
                if (a_done) nd++;
            end
            chk("b2b_accepts", nacc, 3);
            chk("b2b_dones", nd, 3);
            exp_frames += 3;
            chk("b2b_fcnt", a_frame_cnt, exp_frames);
        end
        idle_cycles(4);

        // randomized traffic with random hold against a transaction-level model
        begin : rnd
            logic [7:0] src[$];
            logic [7:0] accq[$];
            logic [7:0] w;
            int inflight, since, pending, nb, ndone;
            logic exp_done;
            inflight = 0; since = 1000; pending = 0; nb = 0; ndone = 0; w = 8'h00;
            for (int i = 0; i < 24; i++) src.push_back(8'($urandom));
            for (int c = 0; c < 3000 && ndone < 24; c++) begin
                @(posedge clk); #1;
                a_valid = (src.size() > 0) && ($urandom_range(0, 2) != 0);
                a_data  = (src.size() > 0) ? src[0] : 8'h00;
                a_hold  = ($urandom_range(0, 3) == 0);
                a_abort = 1'b0;
                @(negedge clk);
                exp_done = (pending != 0);
                if (pending != 0) begin
                    exp_frames++;
                    ndone++;
                    inflight = 0;
                    since = 0;
                    pending = 0;
                end else if (since < 1000) begin
                    since++;
                end
                chk("rnd_done", a_done, exp_done);
                chk("rnd_fcnt", a_frame_cnt, 16'(exp_frames));
                chk("rnd_in_ready", a_ready, (inflight == 0) && (since >= GAP));
                if (a_valid && a_ready) begin
                    accq.push_back(src.pop_front());
                    inflight = 1;
                end
                if (a_ser_valid) begin
                    w = {w[6:0], shiftout};
                    nb++;
                    if (nb == 8) begin
                        if (accq.size() > 0) chk("rnd_word", w, accq.pop_front());
                        else chk("rnd_word_unexpected", accq.size(), 1);
                        nb = 0;
                        pending = 1;
                    end
                end
            end
            chk("rnd_frames_done", ndone, 24);
        end
        idle_cycles(2);

        // counter wrap and zero-gap throughput on the second build
        begin : wrap
            int nacc, nd, last;
            nacc = 0; nd = 0; last = 0;
            @(negedge clk);
            chk("wrap_init_fcnt", b_frame_cnt, 0);
            chk("wrap_init_ready", b_ready, 1);
            for (int c = 0; c < 100 && nd < 5; c++) begin
                @(posedge clk); #1;
                b_valid = (nacc < 5);
                b_data  = 8'($urandom);
                @(negedge clk);
                if (b_done) begin
                    nd++;
                    chk($sformatf("wrap_fcnt%0d", nd), b_frame_cnt, nd % 4);
                    chk("gap0_ready_at_done", b_ready, 1);
                end
                if (b_valid && b_ready) begin
                    if (nacc > 0) chk("gap0_spacing", c - last, 10);
                    last = c;
                    nacc++;
                end
            end
            chk("wrap_dones", nd, 5);
        end
        idle_cycles(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
